sam_mem_ctrl: RTL and testbench

Sequencing controller between the instruction decoder and the shared 16x16384 RAM. It accepts one decoded command at a time over a valid/ready handshake and performs single-word writes. It streams inclusive address-range reads out as an AXI-Stream-style burst with backpressure and `out_last`. On `go` it hands the RAM port to the SAM engine until that engine signals completion.

---
 rtl/sam_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sam_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sam_mem_ctrl.sv
// Sequencing controller between the decoder and the shared RAM: single writes, streamed range reads, SAM hand-off.
// Optional wrap-around reads are enabled by defining SAM_MEM_CTRL_WRAP_EN.
module sam_mem_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic              cmd_rd,
    input  logic              cmd_go,
    input  logic [ADDR_W-1:0] cmd_wr_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    input  logic [ADDR_W-1:0] cmd_rd_start,
    input  logic [ADDR_W-1:0] cmd_rd_end,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              sam_grant,
    input  logic [ADDR_W-1:0] sam_addr,
    input  logic [DATA_W-1:0] sam_din,
    input  logic              sam_wen,
    input  logic              sam_done,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SAM   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] rd_end_q, rd_end_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] fifo_dat_q [FIFO_DEPTH];
    logic              fifo_lst_q [FIFO_DEPTH];

    logic fifo_empty, accept, issue, push, pop;
    logic [PTR_W:0] occ;

    assign fifo_empty = (cnt_q == '0);
    assign cmd_ready  = (state_q == S_IDLE) && fifo_empty;
    assign accept     = cmd_valid && cmd_ready;
    // Reserve a FIFO slot for every read still in the RAM pipeline so a stalled stream never overflows.
    assign occ        = cnt_q + {{PTR_W{1'b0}}, infl_q};
    assign issue      = (state_q == S_READ) && (occ < DEPTH_C);
    assign push       = infl_q;
    assign pop        = out_valid && out_ready;

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : {{(OUT_W-DATA_W){1'b0}}, fifo_dat_q[rd_ptr_q]};
    assign out_last  = !fifo_empty && fifo_lst_q[rd_ptr_q];
    assign sam_grant = (state_q == S_SAM);
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_wen  = 1'b0;
        case (state_q)
            S_WRITE: begin
                ram_addr = wr_addr_q;
                ram_din  = wr_data_q;
                ram_wen  = 1'b1;
            end
            S_READ:  ram_addr = rd_addr_q;
            S_SAM: begin
                ram_addr = sam_addr;
                ram_din  = sam_din;
                ram_wen  = sam_wen;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rd_end_d    = rd_end_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                if (cmd_go) begin
                    state_d = S_SAM;
                end else if (cmd_rd) begin
                    state_d   = S_READ;
                    rd_addr_d = cmd_rd_start;
`ifdef SAM_MEM_CTRL_WRAP_EN
                    rd_end_d  = cmd_rd_end;
`else
                    rd_end_d  = (cmd_rd_end < cmd_rd_start) ? cmd_rd_start : cmd_rd_end;
`endif
                end else if (cmd_wr) begin
                    state_d   = S_WRITE;
                    wr_addr_d = cmd_wr_addr;
                    wr_data_d = cmd_wr_data;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: if (issue) begin
                rd_addr_d   = rd_addr_q + 1'b1;
                infl_d      = 1'b1;
                infl_last_d = (rd_addr_q == rd_end_q);
                if (rd_addr_q == rd_end_q) state_d = S_DRAIN;
            end
            S_DRAIN: if (fifo_empty && !infl_q) state_d = S_IDLE;
            S_SAM:   if (sam_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_end_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            rd_end_q    <= rd_end_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: occupancy gates every output that reads it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat_q[wr_ptr_q] <= ram_dout;
            fifo_lst_q[wr_ptr_q] <= infl_last_q;
        end
    end
endmodule

// File: tb/tb_sam_mem_ctrl.sv
// Directed bench for sam_mem_ctrl with a behavioural 16x16384 synchronous RAM.
module tb_sam_mem_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid = 0, cmd_wr = 0, cmd_rd = 0, cmd_go = 0;
    logic [13:0] cmd_wr_addr = 0, cmd_rd_start = 0, cmd_rd_end = 0;
    logic [15:0] cmd_wr_data = 0;
    logic        cmd_ready;
    logic [13:0] ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        ram_wen, sam_grant;
    logic [13:0] sam_addr = 0;
    logic [15:0] sam_din = 0;
    logic        sam_wen = 0, sam_done = 0;
    logic [31:0] out_data;
    logic        out_valid, out_ready = 0, out_last, busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [15:0] ram [16384];
    logic [15:0] ref_mem [16384];

    always #5 clk = ~clk;

    sam_mem_ctrl dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_go(cmd_go),
        .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .cmd_rd_start(cmd_rd_start), .cmd_rd_end(cmd_rd_end),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen), .ram_dout(ram_dout),
        .sam_grant(sam_grant), .sam_addr(sam_addr), .sam_din(sam_din),
        .sam_wen(sam_wen), .sam_done(sam_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always @(posedge clk) begin
        if (ram_wen) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_cmd();
        cmd_valid = 0; cmd_wr = 0; cmd_rd = 0; cmd_go = 0;
    endtask

    // Waits for cmd_ready at a falling edge, then presents the command for the next rising edge.
    task automatic do_cmd(input logic wr, input logic rd, input logic go,
                          input logic [13:0] wa, input logic [15:0] wd,
                          input logic [13:0] rs, input logic [13:0] re);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        if (!cmd_ready) chk("cmd_timeout", {31'b0, cmd_ready}, 1);
        cmd_valid = 1; cmd_wr = wr; cmd_rd = rd; cmd_go = go;
        cmd_wr_addr = wa; cmd_wr_data = wd; cmd_rd_start = rs; cmd_rd_end = re;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] d);
        do_cmd(1, 0, 0, a, d, 0, 0);
        @(negedge clk); clr_cmd();
        chk("wr_wen", {31'b0, ram_wen}, 1);
        chk("wr_addr", {18'b0, ram_addr}, {18'b0, a});
        chk("wr_din", {16'b0, ram_din}, {16'b0, d});
        chk("wr_rdy_lo", {31'b0, cmd_ready}, 0);
        @(negedge clk);
        chk("wr_rdy_back", {31'b0, cmd_ready}, 1);
        chk("wr_wen_off", {31'b0, ram_wen}, 0);
        ref_mem[a] = d;
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeating.
    task automatic run_read(input logic [13:0] rs, input logic [13:0] re, input int mode, input logic wr_too);
        int n_exp, got, k, first_v, wen_seen, extra;
        logic [31:0] prev_d;
        logic prev_l, prev_stall;
        logic [13:0] a;
`ifdef SAM_MEM_CTRL_WRAP_EN
        n_exp = int'(14'(re - rs)) + 1;
`else
        n_exp = (re < rs) ? 1 : int'(re - rs) + 1;
`endif
        got = 0; k = 0; first_v = -1; wen_seen = 0; extra = 0; prev_stall = 0;
        prev_d = 0; prev_l = 0;
        do_cmd(wr_too, 1, 0, 14'h0300, 16'h5555, rs, re);
        while (got < n_exp && k < 200) begin
            @(negedge clk); k++;
            if (k == 1) clr_cmd();
            if (ram_wen) wen_seen++;
            if (prev_stall) begin
                chk("hold_data", out_data, prev_d);
                chk("hold_last", {31'b0, out_last}, {31'b0, prev_l});
            end
            if (out_valid && first_v < 0) begin
                first_v = k;
                chk("first_latency", k, 3);
            end
            chk("rdy_during_burst", {31'b0, cmd_ready}, 0);
            out_ready = (mode == 0) ? 1'b1 : ((k % 4 == 1) || (k % 4 == 0));
            if (out_valid && out_ready) begin
                a = rs + 14'(got);
                chk("beat_data", out_data, {16'b0, ref_mem[a]});
                chk("beat_last", {31'b0, out_last}, (got == n_exp - 1) ? 32'd1 : 32'd0);
                if (mode == 0) chk("throughput", k, 3 + got);
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
        if (got < n_exp) chk("burst_timeout", got, n_exp);
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
            if (ram_wen) wen_seen++;
        end
        chk("extra_beats", extra, 0);
        chk("read_no_wen", wen_seen, 0);
        chk("read_idle", {31'b0, cmd_ready}, 1);
        out_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin ram[i] = 16'h0; ref_mem[i] = 16'h0; end
        rstn = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_ram_wen", {31'b0, ram_wen}, 0);
        chk("rst_ram_addr", {18'b0, ram_addr}, 0);
        chk("rst_ram_din", {16'b0, ram_din}, 0);
        chk("rst_sam_grant", {31'b0, sam_grant}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_last", {31'b0, out_last}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rstn = 1;

        do_write(14'h0005, 16'h1234);
        run_read(14'h0005, 14'h0005, 0, 0);

        do_write(14'h0010, 16'hAAAA);
        do_write(14'h0011, 16'hBBBB);
        do_write(14'h0012, 16'hCCCC);
        do_write(14'h0013, 16'hDDDD);
        run_read(14'h0010, 14'h0013, 1, 0);

        do_write(14'h3FFE, 16'h0A0A);
        do_write(14'h3FFF, 16'h0B0B);
        do_write(14'h0000, 16'h0C0C);
        do_write(14'h0001, 16'h0D0D);
        run_read(14'h3FFE, 14'h0001, 0, 0);

        // SAM requests outside the grant must not reach the RAM.
        @(negedge clk);
        sam_addr = 14'h0200; sam_din = 16'hDEAD; sam_wen = 1;
        @(negedge clk);
        chk("sam_leak_wen", {31'b0, ram_wen}, 0);
        chk("sam_grant_idle", {31'b0, sam_grant}, 0);
        sam_wen = 0;
        do_cmd(0, 0, 1, 0, 0, 0, 0);
        @(negedge clk); clr_cmd();
        chk("sam_grant_on", {31'b0, sam_grant}, 1);
        sam_addr = 14'h0100; sam_din = 16'hBEEF; sam_wen = 1;
        @(negedge clk);
        chk("sam_mux_wen", {31'b0, ram_wen}, 1);
        chk("sam_mux_addr", {18'b0, ram_addr}, 32'h100);
        chk("sam_mux_din", {16'b0, ram_din}, 32'hBEEF);
        chk("sam_grant_hold", {31'b0, sam_grant}, 1);
        sam_wen = 0; sam_done = 1;
        @(negedge clk);
        sam_done = 0;
        chk("sam_grant_off", {31'b0, sam_grant}, 0);
        sam_addr = 14'h0200; sam_din = 16'hDEAD; sam_wen = 1;
        @(negedge clk);
        chk("sam_leak_after", {31'b0, ram_wen}, 0);
        sam_wen = 0;
        ref_mem[14'h0100] = 16'hBEEF;
        run_read(14'h0100, 14'h0100, 0, 0);
        run_read(14'h0200, 14'h0200, 0, 0);

        // Read and write bits together: read wins, nothing lands at 0x0300.
        run_read(14'h0005, 14'h0005, 0, 1);
        run_read(14'h0300, 14'h0300, 0, 0);

        // Command with no type bit is dropped.
        do_cmd(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); clr_cmd();
        chk("nop_ready", {31'b0, cmd_ready}, 1);
        chk("nop_busy", {31'b0, busy}, 0);

        for (int i = 0; i < 8; i++) do_write(14'h0020 + 14'(i), 16'hA000 + 16'(i));
        begin
            int k = 0;
            int pops = 0;
            do_cmd(0, 1, 0, 0, 0, 14'h0020, 14'h0027);
            while (k < 50) begin
                @(negedge clk); k++;
                if (k == 1) clr_cmd();
                out_ready = 1;
                if (out_valid && pops == 1) break;
                if (out_valid) pops++;
            end
            chk("mid_beat2_data", out_data, 32'h0000A001);
            #1 rstn = 0;
            #1;
            chk("mid_rst_valid", {31'b0, out_valid}, 0);
            chk("mid_rst_last", {31'b0, out_last}, 0);
            chk("mid_rst_data", out_data, 0);
            chk("mid_rst_ready", {31'b0, cmd_ready}, 1);
            chk("mid_rst_busy", {31'b0, busy}, 0);
            @(negedge clk);
            @(negedge clk);
            rstn = 1;
            out_ready = 0;
            @(negedge clk);
            chk("post_rst_ready", {31'b0, cmd_ready}, 1);
            chk("post_rst_valid", {31'b0, out_valid}, 0);
        end
        run_read(14'h0020, 14'h0021, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
